// File: rtl/mano_cache_if.sv
// Control-path and main-memory signal bundle for mano_cache.
// slave is the cache's view; master is the control path plus main memory.
interface mano_cache_if #(
  parameter int DATAW = 16,
  parameter int ADDRW = 12
);
  logic             cs_mem_rd;
  logic             cs_mem_wr;
  logic [ADDRW-1:0] addr;
  logic [DATAW-1:0] wdata;
  logic [DATAW-1:0] rdata;
  logic             cache_hit;
  logic             mem_req;
  logic             mem_we;
  logic [ADDRW-1:0] mem_addr;
  logic [DATAW-1:0] mem_wdata;
  logic [DATAW-1:0] mem_rdata;
  logic             mem_ack;

  modport slave (
    input  cs_mem_rd, cs_mem_wr, addr, wdata, mem_rdata, mem_ack,
    output rdata, cache_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cs_mem_rd, cs_mem_wr, addr, wdata, mem_rdata, mem_ack,
    input  rdata, cache_hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mano_cache.sv
// Direct-mapped, write-through, single-word-line cache for the MANO datapath.
// Define MANO_CACHE_STATS_EN to add saturating read hit/miss counters.
//
// state | meaning
// IDLE  | lookup; read hits answered combinationally, misses/writes latched
// FILL  | reading the missed word from main memory, waiting for mem_ack
// WRITE | writing the latched word through to main memory, waiting for mem_ack
// DONE  | one-cycle completion, rdata from the response register
module mano_cache #(
  parameter int DATAW = 16,
  parameter int ADDRW = 12,
  parameter int IDXW  = 4
) (
  input  logic        mclk,
  input  logic        mrst,
  mano_cache_if.slave bus
`ifdef MANO_CACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);
  localparam int TAGW  = ADDRW - IDXW;
  localparam int LINES = 1 << IDXW;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t           state_q, state_nx;
  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [DATAW-1:0] data_q [LINES];
  logic [ADDRW-1:0] addr_q;
  logic [DATAW-1:0] mem_wdata_q;
  logic [DATAW-1:0] resp_q;
  logic             mem_req_q;
  logic             mem_we_q;

  logic [IDXW-1:0]  idx, idx_q;
  logic [TAGW-1:0]  tag, tag_lat;
  logic             lookup_hit;
  logic             rd_hit;
  logic             line_we;
  logic [DATAW-1:0] line_wdata;

  assign idx        = bus.addr[IDXW-1:0];
  assign tag        = bus.addr[ADDRW-1:IDXW];
  assign idx_q      = addr_q[IDXW-1:0];
  assign tag_lat    = addr_q[ADDRW-1:IDXW];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_hit     = (state_q == IDLE) && bus.cs_mem_rd && !bus.cs_mem_wr && lookup_hit;
  assign line_we    = bus.mem_ack && ((state_q == FILL) || (state_q == WRITE));
  assign line_wdata = (state_q == FILL) ? bus.mem_rdata : mem_wdata_q;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) state_q <= IDLE;
    else      state_q <= state_nx;
  end

  always_comb begin
    state_nx      = state_q;
    bus.cache_hit = 1'b0;
    bus.rdata     = '0;
    case (state_q)
      IDLE: begin
        if (bus.cs_mem_wr) begin
          state_nx = WRITE;
        end else if (bus.cs_mem_rd && !lookup_hit) begin
          state_nx = FILL;
        end else begin
          bus.cache_hit = 1'b1;
          if (rd_hit) bus.rdata = data_q[idx];
        end
      end
      FILL, WRITE: begin
        if (bus.mem_ack) state_nx = DONE;
      end
      DONE: begin
        state_nx      = IDLE;
        bus.cache_hit = 1'b1;
        bus.rdata     = resp_q;
      end
      default: state_nx = IDLE;
    endcase
    // The sequencer must stay frozen while reset is held.
    if (mrst) begin
      bus.cache_hit = 1'b0;
      bus.rdata     = '0;
    end
  end

  // Memory-side outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      addr_q      <= '0;
      mem_wdata_q <= '0;
      resp_q      <= '0;
      valid_q     <= '0;
    end else begin
      mem_req_q <= (state_nx == FILL) || (state_nx == WRITE);
      mem_we_q  <= (state_nx == WRITE);
      if ((state_q == IDLE) && (state_nx != IDLE)) addr_q <= bus.addr;
      if ((state_q == IDLE) && bus.cs_mem_wr) mem_wdata_q <= bus.wdata;
      if (line_we) valid_q[idx_q] <= 1'b1;
      if ((state_q == FILL) && bus.mem_ack) resp_q <= bus.mem_rdata;
    end
  end

  always_ff @(posedge mclk) begin
    if (line_we) begin
      tag_q[idx_q]  <= tag_lat;
      data_q[idx_q] <= line_wdata;
    end
  end

`ifdef MANO_CACHE_STATS_EN
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (rd_hit && (hit_cnt != 16'hFFFF)) hit_cnt <= hit_cnt + 16'd1;
      if ((state_q == IDLE) && (state_nx == FILL) && (miss_cnt != 16'hFFFF))
        miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mano_cache.sv
// Directed bench for mano_cache; build with MANO_CACHE_STATS_EN to also cover the counters.
module tb_mano_cache;
  logic mclk = 1'b0;
  logic mrst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;

  mano_cache_if #(.DATAW(16), .ADDRW(12)) bus ();

`ifdef MANO_CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  mano_cache #(.DATAW(16), .ADDRW(12), .IDXW(4)) dut (
    .mclk (mclk),
    .mrst (mrst),
    .bus  (bus)
`ifdef MANO_CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic next();
    @(posedge mclk);
    #1;
  endtask

  task automatic bump(inout int cnt);
    if (cnt < 65535) cnt++;
  endtask

  // Full miss or write transaction with memory latency lat (ack in FILL/WRITE cycle lat+1).
  task automatic slow_access(input logic rd, input logic wr, input logic [11:0] a,
                             input logic [15:0] wd, input int lat, input logic [15:0] mrd,
                             input string tag);
    bus.cs_mem_rd = rd;
    bus.cs_mem_wr = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    #2;
    check({tag, " req cache_hit"}, bus.cache_hit, 0);
    check({tag, " req mem_req"}, bus.mem_req, 0);
    if (rd && !wr) bump(exp_miss);
    next();
    bus.cs_mem_rd = 1'b0;
    bus.cs_mem_wr = 1'b0;
    bus.addr      = ~a;
    bus.wdata     = ~wd;
    for (int c = 1; c <= lat + 1; c++) begin
      if (c == lat + 1) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mrd;
      end else begin
        bus.mem_rdata = ~mrd;
      end
      #2;
      check({tag, " stall cache_hit"}, bus.cache_hit, 0);
      check({tag, " stall mem_req"}, bus.mem_req, 1);
      check({tag, " stall mem_we"}, bus.mem_we, wr);
      check({tag, " stall mem_addr"}, bus.mem_addr, a);
      if (wr) check({tag, " stall mem_wdata"}, bus.mem_wdata, wd);
      next();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
    end
    #2;
    check({tag, " done cache_hit"}, bus.cache_hit, 1);
    check({tag, " done mem_req"}, bus.mem_req, 0);
    if (!wr) check({tag, " done rdata"}, bus.rdata, mrd);
    next();
    #2;
    check({tag, " after done mem_req"}, bus.mem_req, 0);
    next();
  endtask

  task automatic hit_read(input logic [11:0] a, input logic [15:0] exp, input string tag);
    bus.cs_mem_rd = 1'b1;
    bus.addr      = a;
    #2;
    check({tag, " cache_hit"}, bus.cache_hit, 1);
    check({tag, " rdata"}, bus.rdata, exp);
    check({tag, " mem_req"}, bus.mem_req, 0);
    bump(exp_hits);
    next();
    bus.cs_mem_rd = 1'b0;
    bus.addr      = '0;
  endtask

  initial begin
    bus.cs_mem_rd = 1'b0;
    bus.cs_mem_wr = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;

    next();
    next();
    #2;
    check("rst cache_hit", bus.cache_hit, 0);
    check("rst mem_req", bus.mem_req, 0);
    check("rst mem_we", bus.mem_we, 0);
    check("rst rdata", bus.rdata, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst mem_wdata", bus.mem_wdata, 0);
`ifdef MANO_CACHE_STATS_EN
    check("rst hit_cnt", hit_cnt, 0);
    check("rst miss_cnt", miss_cnt, 0);
`endif
    mrst = 1'b0;
    next();
    #2;
    check("idle cache_hit", bus.cache_hit, 1);
    next();

    slow_access(1, 0, 12'h005, 16'h0000, 3, 16'hBEEF, "miss 005");
    hit_read(12'h005, 16'hBEEF, "hit 005");
`ifdef MANO_CACHE_STATS_EN
    #2;
    check("stats hit_cnt 1", hit_cnt, 1);
    check("stats miss_cnt 1", miss_cnt, 1);
    next();
`endif

    slow_access(1, 0, 12'h015, 16'h0000, 1, 16'h5A5A, "miss 015 alias");
    hit_read(12'h015, 16'h5A5A, "hit 015");
    slow_access(1, 0, 12'h005, 16'h0000, 2, 16'hBEEF, "miss 005 evicted");
    hit_read(12'h005, 16'hBEEF, "hit 005 again");

    slow_access(0, 1, 12'h0A0, 16'h1234, 2, 16'hDEAD, "write miss 0A0");
    hit_read(12'h0A0, 16'h1234, "hit 0A0");
    slow_access(0, 1, 12'h0A0, 16'hABCD, 0, 16'hDEAD, "write hit 0A0");
    hit_read(12'h0A0, 16'hABCD, "hit 0A0 new");

    slow_access(1, 1, 12'h0C7, 16'h7777, 1, 16'hDEAD, "rd+wr 0C7");
    hit_read(12'h0C7, 16'h7777, "hit 0C7");

    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    #2;
    check("stray ack cache_hit", bus.cache_hit, 1);
    next();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    #2;
    check("stray ack mem_req", bus.mem_req, 0);
    next();
    hit_read(12'h0C7, 16'h7777, "hit 0C7 post ack");

    bus.cs_mem_rd = 1'b1;
    bus.addr      = 12'h033;
    next();
    bus.cs_mem_rd = 1'b0;
    bus.addr      = '0;
    next();
    mrst        = 1'b1;
    bus.mem_ack = 1'b1;
    #2;
    check("mid rst mem_req", bus.mem_req, 0);
    check("mid rst cache_hit", bus.cache_hit, 0);
    check("mid rst rdata", bus.rdata, 0);
    check("mid rst mem_addr", bus.mem_addr, 0);
    next();
    bus.mem_ack = 1'b0;
    mrst        = 1'b0;
    exp_hits    = 0;
    exp_miss    = 0;
    #2;
    check("post rst cache_hit", bus.cache_hit, 1);
    check("post rst mem_req", bus.mem_req, 0);
    next();
    slow_access(1, 0, 12'h033, 16'h0000, 2, 16'h3333, "miss 033 post rst");
    slow_access(1, 0, 12'h0C7, 16'h0000, 1, 16'h1111, "miss 0C7 post rst");
    hit_read(12'h0C7, 16'h1111, "hit 0C7 refilled");

`ifdef MANO_CACHE_STATS_EN
    #2;
    check("stats miss_cnt post rst", miss_cnt, exp_miss);
    check("stats hit_cnt post rst", hit_cnt, exp_hits);
    bus.cs_mem_rd = 1'b1;
    bus.addr      = 12'h0C7;
    for (int i = 0; i < 70000; i++) next();
    bus.cs_mem_rd = 1'b0;
    bus.addr      = '0;
    exp_hits = (exp_hits + 70000 > 65535) ? 65535 : exp_hits + 70000;
    #2;
    check("stats hit_cnt sat", hit_cnt, exp_hits);
    check("stats miss_cnt final", miss_cnt, exp_miss);
    next();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
